imem_sync_ctrl: RTL

//  Parametrised DM->IM coherence controller for the split-SPRAM main memory. Logs data-memory write

---
 rtl/imem_sync_ctrl_if.sv | 38 +++
 rtl/imem_sync_ctrl.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/imem_sync_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : imem_sync_ctrl_if
// Purpose  : Memory-side bundle of the IM/DM coherence controller. Both SPRAM
//            ports (instruction memory write/fetch, data memory access) are
//            carried here.
// Signals  : o_imem_addr/o_imem_wen/o_imem_wdata  IM address, write, data
//            o_dmem_addr/o_dmem_wen/o_dmem_ben/o_dmem_wdata  DM access
//            i_dmem_rdata                         DM read data
//            master : controller side, slave : memory side
// Revision : 1.0  initial release
// ============================================================================
interface imem_sync_ctrl_if #(
  parameter int ADDR_W = 14,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0]   o_imem_addr;
  logic                o_imem_wen;
  logic [DATA_W-1:0]   o_imem_wdata;
  logic [ADDR_W-1:0]   o_dmem_addr;
  logic                o_dmem_wen;
  logic [DATA_W/8-1:0] o_dmem_ben;
  logic [DATA_W-1:0]   o_dmem_wdata;
  logic [DATA_W-1:0]   i_dmem_rdata;

  modport master (
    output o_imem_addr, o_imem_wen, o_imem_wdata,
    output o_dmem_addr, o_dmem_wen, o_dmem_ben, o_dmem_wdata,
    input  i_dmem_rdata
  );

  modport slave (
    input  o_imem_addr, o_imem_wen, o_imem_wdata,
    input  o_dmem_addr, o_dmem_wen, o_dmem_ben, o_dmem_wdata,
    output i_dmem_rdata
  );
endinterface
`default_nettype wire

// File: rtl/imem_sync_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : imem_sync_ctrl
// Purpose  : DM->IM coherence controller for split-SPRAM main memory. Logs
//            data-memory write addresses; on fence.i or a full log, replays
//            each logged word from DM into IM. Passes core traffic through
//            while idle and drives replay traffic while syncing.
// Ports    : clk, i_rst        clock, synchronous active-high reset
//            i_im_addr         core instruction fetch address
//            i_dm_wen/ben/addr/wdata  core data access
//            i_fence_i         sync request pulse
//            o_ready           core requests accepted this cycle
//            o_log_count       number of valid log entries
//            mem               IM/DM memory ports (master modport)
// Revision : 1.0  initial release
// ============================================================================
module imem_sync_ctrl #(
  parameter int ADDR_W = 14,
  parameter int DATA_W = 32,
  parameter int LOG_AW = 8,
  parameter int RD_LAT = 1,
  parameter bit DEDUP  = 1'b1
) (
  input  wire                clk,
  input  wire                i_rst,
  input  wire [ADDR_W-1:0]   i_im_addr,
  input  wire                i_dm_wen,
  input  wire [DATA_W/8-1:0] i_dm_ben,
  input  wire [ADDR_W-1:0]   i_dm_addr,
  input  wire [DATA_W-1:0]   i_dm_wdata,
  input  wire                i_fence_i,
  output logic               o_ready,
  output logic [LOG_AW:0]    o_log_count,
  imem_sync_ctrl_if.master   mem
);

  localparam int               DEPTH        = 2 ** LOG_AW;
  localparam int               DRN_W        = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  localparam logic [LOG_AW:0]  C_DEPTH      = (LOG_AW + 1)'(DEPTH);
  localparam logic [LOG_AW:0]  C_ONE        = (LOG_AW + 1)'(1);
  localparam logic [DRN_W-1:0] C_DRAIN_INIT = DRN_W'(RD_LAT - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SYNC  = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  state_t            r_state;
  logic [LOG_AW:0]   r_count;
  logic [LOG_AW:0]   r_ptr;
  logic [ADDR_W-1:0] r_log [DEPTH];
  logic [ADDR_W-1:0] r_last_addr;
  logic [DRN_W-1:0]  r_drain;
  // Replay read pipeline: entry i holds the read issued i+1 cycles ago, so
  // the last stage lines up with DM read data arriving RD_LAT cycles later.
  logic [RD_LAT-1:0] r_pipe_vld;
  logic [ADDR_W-1:0] r_pipe_addr [RD_LAT];

  logic              w_idle;
  logic              w_ready;
  logic              w_wr;
  logic              w_dup;
  logic              w_log_wr;
  logic [LOG_AW:0]   w_count_nxt;
  logic [ADDR_W-1:0] w_rd_addr;

  assign w_idle      = (r_state == ST_IDLE);
  assign w_ready     = w_idle && (r_count < C_DEPTH);
  assign w_wr        = w_ready && i_dm_wen && !i_rst;
  // Only the newest entry is compared, so the check costs one register.
  assign w_dup       = DEDUP && (r_count != '0) && (i_dm_addr == r_last_addr);
  assign w_log_wr    = w_wr && !w_dup;
  assign w_count_nxt = r_count + (LOG_AW + 1)'(w_log_wr);
  assign w_rd_addr   = r_log[r_ptr[LOG_AW-1:0]];

  assign o_ready     = w_ready;
  assign o_log_count = r_count;

  assign mem.o_dmem_addr  = w_idle ? i_dm_addr : w_rd_addr;
  assign mem.o_dmem_wen   = w_wr;
  assign mem.o_dmem_ben   = i_dm_ben;
  assign mem.o_dmem_wdata = i_dm_wdata;

  // Reset suppresses a replay write still in the pipeline in the same cycle,
  // so an abort never lets another IM word through.
  assign mem.o_imem_wen   = r_pipe_vld[RD_LAT-1] && !i_rst;
  assign mem.o_imem_addr  = r_pipe_vld[RD_LAT-1] ? r_pipe_addr[RD_LAT-1] : i_im_addr;
  assign mem.o_imem_wdata = mem.i_dmem_rdata;

  // Log storage: no reset needed, r_count qualifies every entry.
  always_ff @(posedge clk) begin
    if (w_log_wr) begin
      r_log[r_count[LOG_AW-1:0]] <= i_dm_addr;
    end
  end

  always_ff @(posedge clk) begin
    if (i_rst) begin
      r_state     <= ST_IDLE;
      r_count     <= '0;
      r_ptr       <= '0;
      r_last_addr <= '0;
      r_drain     <= '0;
      r_pipe_vld  <= '0;
      for (int i = 0; i < RD_LAT; i++) begin
        r_pipe_addr[i] <= '0;
      end
    end else begin
      for (int i = RD_LAT - 1; i > 0; i--) begin
        r_pipe_vld[i]  <= r_pipe_vld[i-1];
        r_pipe_addr[i] <= r_pipe_addr[i-1];
      end
      r_pipe_vld[0]  <= (r_state == ST_SYNC);
      r_pipe_addr[0] <= w_rd_addr;

      case (r_state)
        ST_IDLE: begin
          r_ptr   <= '0;
          r_count <= w_count_nxt;
          if (w_log_wr) begin
            r_last_addr <= i_dm_addr;
          end
          // A write in the fence cycle is already counted in w_count_nxt,
          // so the sync that follows includes it.
          if ((i_fence_i && (w_count_nxt != '0)) || (w_count_nxt == C_DEPTH)) begin
            r_state <= ST_SYNC;
          end
        end
        ST_SYNC: begin
          r_ptr <= r_ptr + C_ONE;
          if (r_ptr == (r_count - C_ONE)) begin
            r_state <= ST_DRAIN;
            r_drain <= C_DRAIN_INIT;
          end
        end
        ST_DRAIN: begin
          if (r_drain == '0) begin
            r_state <= ST_IDLE;
            r_count <= '0;
          end else begin
            r_drain <= r_drain - DRN_W'(1);
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
